// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction fetch stage with program memory and 2-entry prefetch buffer
// Presents one decoded 8-bit instruction per cycle over a valid/ready handshake.
module cpu_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          run,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [7:0]    inst,
  output logic [AW-1:0] inst_pc,
  output logic [1:0]    op,
  output logic [1:0]    dest_addr,
  output logic [1:0]    src1_addr,
  output logic [1:0]    src2_addr,
  output logic [AW-1:0] fetch_pc
);

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_q;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]    count_q, count_d;
  logic [7:0]    data0_q, data0_d, data1_q, data1_d;
  logic [AW-1:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic          pop, push, issue;
  logic [2:0]    occupancy;
  logic [1:0]    wpos;

  always_comb begin
    pop       = (count_q != 2'd0) && inst_ready;
    push      = pend_q && !redirect_valid;
    // Occupancy counts the pending read too, so a push can never land on a full buffer.
    occupancy = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
    issue     = run && !redirect_valid && (occupancy < 3'd2);
    wpos      = count_q - {1'b0, pop};

    fetch_pc_d = issue ? fetch_pc_q + AW'(1) : fetch_pc_q;
    pend_d     = issue;
    pend_pc_d  = issue ? fetch_pc_q : pend_pc_q;
    count_d    = count_q - {1'b0, pop} + {1'b0, push};
    data0_d    = data0_q;
    data1_d    = data1_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;

    if (pop) begin
      data0_d = data1_q;
      pc0_d   = pc1_q;
    end
    if (push) begin
      if (wpos == 2'd0) begin
        data0_d = rd_data_q;
        pc0_d   = pend_pc_q;
      end else begin
        data1_d = rd_data_q;
        pc1_d   = pend_pc_q;
      end
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      pend_d     = 1'b0;
      count_d    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      count_q    <= 2'd0;
      data0_q    <= 8'd0;
      data1_q    <= 8'd0;
      pc0_q      <= '0;
      pc1_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      count_q    <= count_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
    end
  end

  // Memory is not reset; a same-cycle write to the read address yields the old word.
  always_ff @(posedge clk) begin
    if (prog_we && !reset) mem[prog_addr] <= prog_data;
    if (issue) rd_data_q <= mem[fetch_pc_q];
  end

  assign inst_valid = (count_q != 2'd0);
  assign inst       = data0_q;
  assign inst_pc    = pc0_q;
  assign op         = data0_q[7:6];
  assign dest_addr  = data0_q[5:4];
  assign src1_addr  = data0_q[3:2];
  assign src2_addr  = data0_q[1:0];
  assign fetch_pc   = fetch_pc_q;

endmodule
